// File: rtl/module_display_bcd_7seg.sv
// module_display_bcd_7seg
//   Converts the binary word from the Gray decoder to BCD with a sequential
//   shift-add-3 (double-dabble) FSM. Drives a time-multiplexed common-anode
//   7-segment display from the most recent completed conversion.
// Ports
//   clk_i        : system clock, rising edge
//   rst_i        : synchronous reset, active-low
//   codigo_bin_i : binary value to display
//   bcd_o        : BCD of the last completed conversion, [3:0] = units
//   busy_o       : high while a conversion is in progress
//   anodo_o      : digit enables, active-low, one-hot-low
//   segmentos_o  : segments {g,f,e,d,c,b,a}, active-low
module module_display_bcd_7seg #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned N_DIGITS        = 2,
    parameter int unsigned DISPLAY_REFRESH = 27000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [WIDTH-1:0]        codigo_bin_i,
    output logic [4*N_DIGITS-1:0]   bcd_o,
    output logic                    busy_o,
    output logic [N_DIGITS-1:0]     anodo_o,
    output logic [6:0]              segmentos_o
);

    localparam int unsigned BCD_W  = 4 * N_DIGITS;
    localparam int unsigned ITER_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned CNT_W  = (DISPLAY_REFRESH > 1) ? $clog2(DISPLAY_REFRESH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    valor_q, valor_d;
    logic [WIDTH-1:0]    bin_sh_q, bin_sh_d;
    logic [BCD_W-1:0]    bcd_sh_q, bcd_sh_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                busy_q, busy_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [N_DIGITS-1:0] anodo_q, anodo_d;
    logic [6:0]          seg_q, seg_d;

    logic [BCD_W-1:0]    bcd_adj_c;
    logic [3:0]          digit_c;

    // Active-low {g,f,e,d,c,b,a} pattern; non-decimal nibbles blank the digit
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // Add-3 correction applied to every BCD nibble before each shift
    always_comb begin
        bcd_adj_c = bcd_sh_q;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (bcd_sh_q[4*i +: 4] >= 4'd5) begin
                bcd_adj_c[4*i +: 4] = bcd_sh_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM: next state and datapath
    always_comb begin
        state_d  = state_q;
        valor_d  = valor_q;
        bin_sh_d = bin_sh_q;
        bcd_sh_d = bcd_sh_q;
        iter_d   = iter_q;
        bcd_d    = bcd_q;

        case (state_q)
            ST_IDLE: begin
                if (codigo_bin_i != valor_q) begin
                    valor_d  = codigo_bin_i;
                    bin_sh_d = codigo_bin_i;
                    bcd_sh_d = '0;
                    iter_d   = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_sh_d, bin_sh_d} = {bcd_adj_c[BCD_W-2:0], bin_sh_q, 1'b0};
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = bcd_sh_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Pick the BCD nibble of the currently scanned digit
    always_comb begin
        digit_c = 4'hF;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit_c = bcd_q[4*i +: 4];
            end
        end
    end

    // Display scan: dwell counter, digit index, anode and segment drive
    always_comb begin
        scan_cnt_d = scan_cnt_q - CNT_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == '0) begin
            scan_cnt_d = CNT_W'(DISPLAY_REFRESH - 1);
            idx_d      = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        // Anode and segments come from the same index so they switch together
        anodo_d = ~(N_DIGITS'(1) << idx_q);
        seg_d   = seg_pattern(digit_c);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            valor_q    <= '0;
            bin_sh_q   <= '0;
            bcd_sh_q   <= '0;
            iter_q     <= '0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
            idx_q      <= '0;
            scan_cnt_q <= CNT_W'(DISPLAY_REFRESH - 1);
            anodo_q    <= '1;
            seg_q      <= 7'h7F;
        end else begin
            state_q    <= state_d;
            valor_q    <= valor_d;
            bin_sh_q   <= bin_sh_d;
            bcd_sh_q   <= bcd_sh_d;
            iter_q     <= iter_d;
            bcd_q      <= bcd_d;
            busy_q     <= busy_d;
            idx_q      <= idx_d;
            scan_cnt_q <= scan_cnt_d;
            anodo_q    <= anodo_d;
            seg_q      <= seg_d;
        end
    end

    assign bcd_o       = bcd_q;
    assign busy_o      = busy_q;
    assign anodo_o     = anodo_q;
    assign segmentos_o = seg_q;

endmodule

// File: tb/tb_module_display_bcd_7seg.sv
// Testbench for module_display_bcd_7seg (WIDTH=4, N_DIGITS=2, DISPLAY_REFRESH=4).
// A cycle-level behavioural model (decimal arithmetic, dwell counters) is
// compared against the DUT on every clock; directed literal checks pin it.
module tb_module_display_bcd_7seg;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned NDIG    = 2;
    localparam int unsigned REFRESH = 4;
    localparam int unsigned LAT     = WIDTH + 1;   // cycles busy per conversion

    logic                clk;
    logic                rst;
    logic [WIDTH-1:0]    codigo;
    logic [4*NDIG-1:0]   bcd;
    logic                busy;
    logic [NDIG-1:0]     anodo;
    logic [6:0]          seg;

    int total = 0;
    int bad   = 0;

    module_display_bcd_7seg #(
        .WIDTH(WIDTH), .N_DIGITS(NDIG), .DISPLAY_REFRESH(REFRESH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .codigo_bin_i(codigo),
        .bcd_o(bcd), .busy_o(busy), .anodo_o(anodo), .segmentos_o(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] pat [16];
    initial begin
        pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    // Behavioural model state
    bit         m_valid = 0;
    int         m_valor, m_busy_left, m_bcd, m_idx, m_dwell;
    logic [1:0] m_an;
    logic [6:0] m_seg;

    task automatic model_step();
        logic [1:0] new_an;
        logic [6:0] new_seg;
        if (!rst) begin
            m_valid = 1; m_valor = 0; m_busy_left = 0; m_bcd = 0;
            m_idx = 0; m_dwell = REFRESH - 1; m_an = 2'b11; m_seg = 7'h7F;
        end else if (m_valid) begin
            new_an  = ~(2'b01 << m_idx);
            new_seg = pat[(m_bcd >> (4 * m_idx)) & 15];
            if (m_dwell == 0) begin
                m_dwell = REFRESH - 1;
                m_idx   = (m_idx + 1) % NDIG;
            end else begin
                m_dwell--;
            end
            if (m_busy_left == 0) begin
                if (int'(codigo) != m_valor) begin
                    m_valor     = int'(codigo);
                    m_busy_left = LAT;
                end
            end else begin
                m_busy_left--;
                if (m_busy_left == 0) m_bcd = to_bcd(m_valor);
            end
            m_an  = new_an;
            m_seg = new_seg;
        end
    endtask

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        model_step();
        #1;
        if (m_valid) begin
            chk("bcd_o",       32'(bcd),   32'(m_bcd));
            chk("busy_o",      32'(busy),  32'(m_busy_left != 0));
            chk("anodo_o",     32'(anodo), 32'(m_an));
            chk("segmentos_o", 32'(seg),   32'(m_seg));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Watch digits for n cycles, checking lit segments per digit
    task automatic watch_digits(input int n, input logic [6:0] s0, input logic [6:0] s1);
        repeat (n) begin
            @(negedge clk);
            chk("one_anode_low", 32'(anodo == 2'b10 || anodo == 2'b01), 32'd1);
            if (anodo == 2'b10) chk("digit0_seg", 32'(seg), 32'(s0));
            if (anodo == 2'b01) chk("digit1_seg", 32'(seg), 32'(s1));
        end
    endtask

    initial begin
        rst = 1'b0;
        codigo = '0;

        // Reset held 3 cycles
        cycles(3);
        chk("rst_anodo", 32'(anodo), 32'h3);
        chk("rst_seg",   32'(seg),   32'h7F);
        chk("rst_bcd",   32'(bcd),   32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        rst = 1'b1;
        cycles(1);
        chk("rel_anodo", 32'(anodo), 32'h2);
        chk("rel_seg",   32'(seg),   32'b1000000);

        // 0 -> 13: busy 5 cycles, result on 6th edge
        codigo = 4'd13;
        cycles(5);
        chk("c13_busy5", 32'(busy), 32'h1);
        chk("c13_pre",   32'(bcd),  32'h0);
        cycles(1);
        chk("c13_bcd",   32'(bcd),  32'h13);
        chk("c13_idle",  32'(busy), 32'h0);
        cycles(1);
        watch_digits(10, 7'b0110000, 7'b1111001);

        // Sweep 0..15
        for (int v = 0; v < 16; v++) begin
            codigo = 4'(v);
            cycles(20);
            chk("sweep_bcd", 32'(bcd), 32'((v / 10) * 16 + v % 10));
        end

        // 5, then 9 mid-conversion
        codigo = 4'd5;
        cycles(2);
        codigo = 4'd9;
        cycles(4);
        chk("mid_bcd5", 32'(bcd), 32'h05);
        cycles(6);
        chk("mid_bcd9", 32'(bcd), 32'h09);

        // Constant 8 for 40 cycles
        codigo = 4'd8;
        cycles(8);
        chk("c8_bcd", 32'(bcd), 32'h08);
        watch_digits(40, 7'b0000000, 7'b1000000);

        // Reset during SHIFT of 12
        codigo = 4'd12;
        cycles(2);
        chk("shift_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        cycles(1);
        chk("midrst_busy",  32'(busy),  32'h0);
        chk("midrst_bcd",   32'(bcd),   32'h0);
        chk("midrst_anodo", 32'(anodo), 32'h3);
        chk("midrst_seg",   32'(seg),   32'h7F);
        rst = 1'b1;
        cycles(7);
        chk("reconv_bcd12", 32'(bcd), 32'h12);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 60; k++) begin
            codigo = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b0;
                cycles(1);
                rst = 1'b1;
            end
            cycles(int'($urandom_range(1, 12)));
        end
        cycles(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
